burst_mem_responder: RTL and testbench

Memory-side responder for the 64-bit, 4-beat burst interface driven by the cache burst controller. It accepts one 256-bit line read or write at a time and stores lines in an internal word array. Reads return four 64-bit beats after a fixed latency; writes absorb four 64-bit beats. It serves as the synthesizable backing memory for the cache subsystem and as the reference responder in controller benches.

---
 rtl/burst_mem_responder_if.sv | 26 ++
 rtl/burst_mem_responder.sv | 156 +++++++++++++++
 tb/tb_burst_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_mem_responder_if.sv
// Burst memory bus between a cache burst controller (master) and the
// burst_mem_responder (slave). 32-bit line address, 64-bit beats, 4 beats per line.
//
// Handshake: a request (mem_read or mem_write with beat 0) is taken only on an
// edge where mem_ready=1. mem_write must stay high for every write beat. A cycle
// with mem_write=0 inside a write burst is a stall. Read beats are presented with
// mem_rvalid=1, and the master must take them; there is no read back-pressure.
interface burst_mem_responder_if;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: line-granular backing memory for the cache burst bus.
// A read returns four 64-bit beats READ_LATENCY cycles after acceptance. A write
// absorbs four beats, and stall cycles are allowed between beats. There is one
// burst in flight at a time.
// Optional macro BURST_MEM_RESP_GAP_EN inserts one idle cycle between read
// beats 1 and 2.
// dbg_state exposes the FSM: 0=IDLE 1=WR 2=RD_WAIT 3=RD_BURST.
module burst_mem_responder #(
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int READ_LATENCY   = 4    // legal 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    burst_mem_responder_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int         LINE_W   = MEM_WORDS_LOG2 - 2;
    localparam int         WORDS    = 1 << MEM_WORDS_LOG2;
    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } state_t;

    state_t                    state_q, state_n;
    logic [1:0]                beat_q, beat_n;
    logic [3:0]                cnt_q, cnt_n;
    logic [LINE_W-1:0]         line_q, line_n;
    logic                      gap_q, gap_n;
    logic                      ready_q;
    logic                      rvalid_q, rvalid_n;
    logic [63:0]               rdata_q, rdata_n;
    logic                      wr_en;
    logic [MEM_WORDS_LOG2-1:0] wr_idx, rd_idx;
    logic [LINE_W-1:0]         req_line;
    logic [63:0]               mem_array [WORDS];
    logic                      unused_addr_bits;

    // Upper line bits are dropped, so addresses alias modulo the array size.
    assign req_line         = bus.mem_addr[MEM_WORDS_LOG2+2:5];
    assign unused_addr_bits = ^{bus.mem_addr[31:MEM_WORDS_LOG2+3], bus.mem_addr[4:0]};

    // Next-state logic, beat and latency counters, and the array write strobe.
    // The latency counter counts down through 0 before the burst starts. The first
    // beat is therefore registered READ_LATENCY edges after acceptance, even when
    // READ_LATENCY=1.
    always_comb begin
        state_n = state_q;
        beat_n  = beat_q;
        cnt_n   = cnt_q;
        line_n  = line_q;
        gap_n   = gap_q;
        wr_en   = 1'b0;
        wr_idx  = {line_q, beat_q};
        case (state_q)
            IDLE: begin
                gap_n = 1'b0;
                if (ready_q && bus.mem_write) begin
                    wr_en   = 1'b1;
                    wr_idx  = {req_line, 2'd0};
                    line_n  = req_line;
                    beat_n  = 2'd1;
                    state_n = WR;
                end else if (ready_q && bus.mem_read) begin
                    line_n  = req_line;
                    cnt_n   = LAT_LOAD;
                    beat_n  = 2'd0;
                    state_n = RD_WAIT;
                end
            end
            WR: begin
                if (bus.mem_write) begin
                    wr_en  = 1'b1;
                    beat_n = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_n = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_n = RD_BURST;
                    beat_n  = 2'd0;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            RD_BURST: begin
`ifdef BURST_MEM_RESP_GAP_EN
                // beat 1 -> gap cycle (beat already advanced to 2) -> beat 2
                if (beat_q == 2'd1 && !gap_q) begin
                    gap_n  = 1'b1;
                    beat_n = 2'd2;
                end else if (gap_q) begin
                    gap_n = 1'b0;
                end else if (beat_q == 2'd3) begin
                    state_n = IDLE;
                    beat_n  = 2'd0;
                end else begin
                    beat_n = beat_q + 2'd1;
                end
`else
                if (beat_q == 2'd3) begin
                    state_n = IDLE;
                    beat_n  = 2'd0;
                end else begin
                    beat_n = beat_q + 2'd1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // Read data is staged from the array at the edge that enters each beat, so
    // the outputs come only from flops.
    always_comb begin
        rd_idx   = {line_n, beat_n};
        rvalid_n = (state_n == RD_BURST) && !gap_n;
        rdata_n  = rvalid_n ? mem_array[rd_idx] : 64'd0;
    end

    // State and output registers. rst abandons any burst that is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            cnt_q    <= 4'd0;
            line_q   <= '0;
            gap_q    <= 1'b0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 64'd0;
        end else begin
            state_q  <= state_n;
            beat_q   <= beat_n;
            cnt_q    <= cnt_n;
            line_q   <= line_n;
            gap_q    <= gap_n;
            ready_q  <= (state_n == IDLE);
            rvalid_q <= rvalid_n;
            rdata_q  <= rdata_n;
        end
    end

    // Storage array. It is not reset, so its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_array[wr_idx] <= bus.mem_wdata;
    end

    assign bus.mem_ready  = ready_q;
    assign bus.mem_rvalid = rvalid_q;
    assign bus.mem_rdata  = rdata_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Testbench for burst_mem_responder. A word-array model feeds an expected-beat
// queue whenever a read is issued. Each test task compares captured beats,
// timing and state against that queue and against fixed timing.
module tb_burst_mem_responder;
    localparam int         MEM_WORDS_LOG2 = 12;
    localparam int         READ_LATENCY   = 4;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_WR = 2'd1, ST_RD_WAIT = 2'd2;
`ifdef BURST_MEM_RESP_GAP_EN
    localparam logic [31:0] EXP_PAT     = 32'b0000_0001_1011_0000;
    localparam int          EXP_READY_K = 9;
`else
    localparam logic [31:0] EXP_PAT     = 32'b0000_0000_1111_0000;
    localparam int          EXP_READY_K = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    burst_mem_responder_if bus ();

    burst_mem_responder #(
        .MEM_WORDS_LOG2(MEM_WORDS_LOG2),
        .READ_LATENCY  (READ_LATENCY)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q [$];
    logic [63:0] model_mem [int];

    // read capture results
    logic [63:0] got [8];
    int          got_n;
    logic [31:0] rv_pat;
    int          first_ready;
    logic        rdata_nz;
    int          acc_wait;
    // write capture results
    logic        saw_rvalid, stall_bad, wr_timeout, ready_after_wr;
    logic [1:0]  st_after_b0;

    function automatic int word_idx(input logic [31:0] addr, input int b);
        return int'(addr[MEM_WORDS_LOG2+2:5]) * 4 + b;
    endfunction

    function automatic logic [63:0] model_word(input int i);
        return model_mem.exists(i) ? model_mem[i] : 64'd0;
    endfunction

    // Driver: the task is called at a negedge and returns at the negedge that
    // follows the last beat.
    task automatic write_line(input logic [31:0] addr, input logic [63:0] d0, d1, d2, d3,
                              input int stall, input logic hold_read);
        logic [63:0] d [4];
        int n;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        saw_rvalid = 0; stall_bad = 0; wr_timeout = 0;
        bus.mem_addr = addr; bus.mem_write = 1'b1; bus.mem_wdata = d[0]; bus.mem_read = hold_read;
        n = 0;
        while (bus.mem_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) wr_timeout = 1;
        @(posedge clk);
        model_mem[word_idx(addr, 0)] = d[0];
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            if (b == 1) st_after_b0 = dbg_state;
            if (b == 2 && stall > 0) begin
                bus.mem_write = 1'b0;
                bus.mem_wdata = {$urandom, $urandom};
                for (int s = 0; s < stall; s++) begin
                    if (dbg_state !== ST_WR) stall_bad = 1;
                    if (bus.mem_rvalid !== 1'b0) saw_rvalid = 1;
                    @(negedge clk);
                end
            end
            bus.mem_write = 1'b1;
            bus.mem_wdata = d[b];
            bus.mem_addr  = {$urandom};
            if (bus.mem_rvalid !== 1'b0) saw_rvalid = 1;
            @(posedge clk);
            model_mem[word_idx(addr, b)] = d[b];
        end
        @(negedge clk);
        bus.mem_write  = 1'b0;
        ready_after_wr = bus.mem_ready;
    endtask

    // Driver and monitor for one read. The task pushes the expected beats and
    // records each cycle after acceptance. It is called at a negedge and returns
    // at a negedge.
    task automatic read_line(input logic [31:0] addr);
        exp_q.delete();
        for (int b = 0; b < 4; b++) exp_q.push_back(model_word(word_idx(addr, b)));
        got_n = 0; rv_pat = '0; first_ready = -1; rdata_nz = 0; acc_wait = 0;
        bus.mem_addr = addr; bus.mem_read = 1'b1;
        while (bus.mem_ready !== 1'b1 && acc_wait < 50) begin @(negedge clk); acc_wait++; end
        @(posedge clk);
        @(negedge clk);
        bus.mem_read = 1'b0;
        bus.mem_addr = {$urandom};
        for (int k = 0; k < 30; k++) begin
            if (bus.mem_rvalid === 1'b1) begin
                rv_pat[k] = 1'b1;
                if (got_n < 8) got[got_n] = bus.mem_rdata;
                got_n++;
            end else if (bus.mem_rdata !== 64'd0) begin
                rdata_nz = 1;
            end
            if (bus.mem_ready === 1'b1) begin first_ready = k; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_read = 0; bus.mem_write = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got=%b exp=0", bus.mem_ready); end
        checks++; if (bus.mem_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got=%b exp=0", bus.mem_rvalid); end
        checks++; if (bus.mem_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got=%h exp=0", bus.mem_rdata); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got=%0d exp=%0d", dbg_state, ST_IDLE); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got=%b exp=1", bus.mem_ready); end
        checks++; if (bus.mem_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid: got=%b exp=0", bus.mem_rvalid); end
        checks++; if (bus.mem_rdata !== 64'd0) begin errors++; $display("FAIL post_reset_rdata: got=%h exp=0", bus.mem_rdata); end
    endtask

    task automatic test_write_read();
        logic [63:0] e;
        write_line(32'h0000_0040, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 0, 1'b0);
        checks++; if (wr_timeout !== 1'b0) begin errors++; $display("FAIL wr_accept: timed out"); end
        checks++; if (saw_rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid: rvalid seen during write"); end
        checks++; if (ready_after_wr !== 1'b1) begin errors++; $display("FAIL wr_ready_after: got=%b exp=1", ready_after_wr); end
        read_line(32'h0000_0040);
        checks++; if (acc_wait !== 0) begin errors++; $display("FAIL rd_accept_wait: got=%0d exp=0", acc_wait); end
        checks++; if (rv_pat !== EXP_PAT) begin errors++; $display("FAIL rd_rvalid_pattern: got=%b exp=%b", rv_pat, EXP_PAT); end
        checks++; if (first_ready !== EXP_READY_K) begin errors++; $display("FAIL rd_ready_return: got=%0d exp=%0d", first_ready, EXP_READY_K); end
        checks++; if (rdata_nz !== 1'b0) begin errors++; $display("FAIL rd_rdata_idle: nonzero rdata with rvalid=0"); end
        checks++; if (got_n !== 4) begin errors++; $display("FAIL rd_beat_count: got=%0d exp=4", got_n); end
        for (int i = 0; i < 4 && i < got_n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL rd_beat%0d: got=%h exp=%h", i, got[i], e); end
        end
    endtask

    task automatic test_write_stall();
        logic [63:0] e;
        write_line(32'h0000_01A0, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, 2, 1'b0);
        checks++; if (stall_bad !== 1'b0) begin errors++; $display("FAIL stall_state: left WR during stall"); end
        checks++; if (saw_rvalid !== 1'b0) begin errors++; $display("FAIL stall_rvalid: rvalid seen during write"); end
        checks++; if (ready_after_wr !== 1'b1) begin errors++; $display("FAIL stall_ready_after: got=%b exp=1", ready_after_wr); end
        read_line(32'h0000_01A0);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL stall_beat_count: got=%0d exp=4", got_n); end
        checks++; if (rv_pat !== EXP_PAT) begin errors++; $display("FAIL stall_rvalid_pattern: got=%b exp=%b", rv_pat, EXP_PAT); end
        for (int i = 0; i < 4 && i < got_n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL stall_beat%0d: got=%h exp=%h", i, got[i], e); end
        end
    endtask

    task automatic test_rw_collision();
        logic [63:0] e;
        write_line(32'h0000_02C0, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b1);
        checks++; if (st_after_b0 !== ST_WR) begin errors++; $display("FAIL coll_write_first: state=%0d exp=%0d", st_after_b0, ST_WR); end
        checks++; if (saw_rvalid !== 1'b0) begin errors++; $display("FAIL coll_rvalid: rvalid during write"); end
        checks++; if (ready_after_wr !== 1'b1) begin errors++; $display("FAIL coll_ready_after: got=%b exp=1", ready_after_wr); end
        read_line(32'h0000_02C0);
        checks++; if (acc_wait !== 0) begin errors++; $display("FAIL coll_read_accept: waited=%0d exp=0", acc_wait); end
        checks++; if (got_n !== 4) begin errors++; $display("FAIL coll_beat_count: got=%0d exp=4", got_n); end
        for (int i = 0; i < 4 && i < got_n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL coll_beat%0d: got=%h exp=%h", i, got[i], e); end
        end
    endtask

    task automatic test_rst_rd_wait();
        logic [63:0] e;
        int n, rv_cnt;
        write_line(32'h0000_0300, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0);
        bus.mem_addr = 32'h0000_0300; bus.mem_read = 1'b1;
        n = 0;
        while (bus.mem_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        bus.mem_read = 1'b0;
        checks++; if (dbg_state !== ST_RD_WAIT) begin errors++; $display("FAIL rstrd_in_wait: state=%0d exp=%0d", dbg_state, ST_RD_WAIT); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstrd_idle: state=%0d exp=%0d", dbg_state, ST_IDLE); end
        checks++; if (bus.mem_rvalid !== 1'b0) begin errors++; $display("FAIL rstrd_rvalid: got=%b exp=0", bus.mem_rvalid); end
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL rstrd_ready_in_rst: got=%b exp=0", bus.mem_ready); end
        rst = 1'b0;
        rv_cnt = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (bus.mem_rvalid !== 1'b0) rv_cnt++; end
        checks++; if (rv_cnt !== 0) begin errors++; $display("FAIL rstrd_no_beats: got=%0d beats exp=0", rv_cnt); end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rstrd_ready_after: got=%b exp=1", bus.mem_ready); end
        read_line(32'h0000_0300);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL rstrd_beat_count: got=%0d exp=4", got_n); end
        for (int i = 0; i < 4 && i < got_n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL rstrd_beat%0d: got=%h exp=%h", i, got[i], e); end
        end
    endtask

    task automatic test_rst_wr();
        logic [63:0] e;
        logic [63:0] nd [4];
        int n;
        write_line(32'h0000_03E0, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0);
        for (int b = 0; b < 4; b++) nd[b] = {$urandom, $urandom};
        bus.mem_addr = 32'h0000_03E0; bus.mem_write = 1'b1; bus.mem_wdata = nd[0];
        n = 0;
        while (bus.mem_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        model_mem[word_idx(32'h0000_03E0, 0)] = nd[0];
        @(negedge clk);
        bus.mem_wdata = nd[1];
        @(posedge clk);
        model_mem[word_idx(32'h0000_03E0, 1)] = nd[1];
        @(negedge clk);
        bus.mem_wdata = nd[2];
        rst = 1'b1;
        @(negedge clk);
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstwr_idle: state=%0d exp=%0d", dbg_state, ST_IDLE); end
        checks++; if (bus.mem_rvalid !== 1'b0) begin errors++; $display("FAIL rstwr_rvalid: got=%b exp=0", bus.mem_rvalid); end
        rst = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
        read_line(32'h0000_03E0);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL rstwr_beat_count: got=%0d exp=4", got_n); end
        for (int i = 0; i < 4 && i < got_n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL rstwr_beat%0d: got=%h exp=%h", i, got[i], e); end
        end
    endtask

    // Random lines are written through an aliased address and read back
    // through the base address with random offset bits.
    task automatic test_alias_random();
        logic [63:0] e;
        logic [31:0] base, alias_addr;
        for (int t = 0; t < 3; t++) begin
            base       = {17'd0, 10'($urandom_range(0, 1023)), 5'd0};
            alias_addr = base | (32'($urandom_range(1, 255)) << 15);
            write_line(alias_addr, {$urandom, $urandom}, {$urandom, $urandom},
                       {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 2)), 1'b0);
            read_line(base | 32'($urandom_range(0, 31)));
            checks++; if (rv_pat !== EXP_PAT) begin errors++; $display("FAIL alias%0d_pattern: got=%b exp=%b", t, rv_pat, EXP_PAT); end
            checks++; if (got_n !== 4) begin errors++; $display("FAIL alias%0d_beat_count: got=%0d exp=4", t, got_n); end
            for (int i = 0; i < 4 && i < got_n && exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                checks++; if (got[i] !== e) begin errors++; $display("FAIL alias%0d_beat%0d: got=%h exp=%h", t, i, got[i], e); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_read = 0; bus.mem_write = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_write_stall();
        test_rw_collision();
        test_rst_rd_wait();
        test_rst_wr();
        test_alias_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
